a2d_conv_seq: RTL



---
 rtl/a2d_pkg.sv | 7 +
 rtl/a2d_avg4.sv | 30 +++
 rtl/a2d_conv_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and constants for the A2D conversion sequencer.
package a2d_pkg;
  typedef enum logic [1:0] {IDLE, TX1, GAP, TX2} state_t;
  localparam logic [1:0]  CMD_PAD     = 2'b00;
  localparam logic [10:0] CMD_LSB_PAD = 11'h000;
  localparam int          RES_W       = 12;
endpackage

// File: rtl/a2d_avg4.sv
// a2d_avg4: 4-sample accumulator and conversion counter for the averaging build.
module a2d_avg4
  import a2d_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add,
  input  logic [RES_W-1:0] sample,
  output logic             last,
  output logic [RES_W-1:0] avg
);
  logic [RES_W+1:0] acc_q, acc_d, sum;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    sum = acc_q + {2'b00, sample};
    acc_d = clr ? '0 : add ? sum : acc_q;
    cnt_d = clr ? '0 : add ? cnt_q + 2'd1 : cnt_q;
  end
  assign last = cnt_q == 2'd3;
  assign avg = sum[RES_W+1:2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/a2d_conv_seq.sv
// a2d_conv_seq: turns a start pulse into two SPI frames (channel select, result read).
// Define A2D_AVG4_EN to average four conversions per request.
module a2d_conv_seq
  import a2d_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int CHNL_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strt_cnv,
  input  logic [CHNL_W-1:0] chnnl,
  output logic              busy,
  output logic              cnv_cmplt,
  output logic [RES_W-1:0]  res,
  output logic              wrt,
  output logic [15:0]       cmd,
  input  logic              done,
  input  logic [15:0]       rd_data
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state_q, state_d;
  logic busy_q, busy_d, cmplt_q, cmplt_d, wrt_q, wrt_d, done_ff_q, rearm_q, rearm_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [CHNL_W-1:0] chnl_q, chnl_d;
  logic [GW-1:0] gap_q, gap_d;
  logic done_rise, last, unused_rd;
  logic [RES_W-1:0] avg;
  // done idles high, so only a 0->1 edge marks the end of a frame
  assign done_rise = done & ~done_ff_q;
  assign unused_rd = ^rd_data[15:RES_W];
`ifdef A2D_AVG4_EN
  logic clr, add;
  assign clr = (state_q == IDLE) && strt_cnv;
  assign add = (state_q == TX2) && done_rise;
  assign rearm_d = add ? !last : (state_q == TX1) ? 1'b0 : rearm_q;
  a2d_avg4 u_avg (.clk, .rst_n, .clr, .add, .sample(rd_data[RES_W-1:0]), .last, .avg);
`else
  assign last = 1'b1;
  assign avg = rd_data[RES_W-1:0];
  assign rearm_d = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    cmplt_d = cmplt_q;
    res_d = res_q;
    wrt_d = 1'b0;
    chnl_d = chnl_q;
    gap_d = gap_q;
    case (state_q)
      IDLE: if (strt_cnv) begin
        chnl_d = chnnl;
        wrt_d = 1'b1;
        busy_d = 1'b1;
        cmplt_d = 1'b0;
        state_d = TX1;
      end
      TX1: if (done_rise) begin
        gap_d = GW'(GAP_CYCLES - 1);
        state_d = GAP;
      end
      GAP: if (gap_q == '0) begin
        wrt_d = 1'b1;
        state_d = rearm_q ? TX1 : TX2;
      end else gap_d = gap_q - 1'b1;
      TX2: if (done_rise) begin
        if (last) begin
          res_d = avg;
          cmplt_d = 1'b1;
          busy_d = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = GW'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      cmplt_q <= 1'b0;
      res_q <= '0;
      wrt_q <= 1'b0;
      chnl_q <= '0;
      gap_q <= '0;
      done_ff_q <= 1'b1;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      cmplt_q <= cmplt_d;
      res_q <= res_d;
      wrt_q <= wrt_d;
      chnl_q <= chnl_d;
      gap_q <= gap_d;
      done_ff_q <= done;
      rearm_q <= rearm_d;
    end
  assign busy = busy_q;
  assign cnv_cmplt = cmplt_q;
  assign res = res_q;
  assign wrt = wrt_q;
  assign cmd = {CMD_PAD, chnl_q[2:0], CMD_LSB_PAD};
endmodule
